// File: rtl/q_fifo_feed_ctrl_if.sv
// Handshake and FIFO-control bundle for q_fifo_feed_ctrl.
//   slave  : the controller side (job control in, upstream word stream in,
//            downstream byte request in; FIFO controls, status out).
//   master : the side that drives the controller (job issuer, upstream
//            producer, downstream consumer, and the FIFO itself).
// Signals:
//   start, num_words                       job request
//   in_valid, in_data, in_ready            upstream 32-bit word stream
//   out_ready, out_valid                   downstream byte request / valid
//   fifo_clr, fifo_write_en,
//   fifo_write_data, fifo_read_en          packing FIFO controls
//   busy, done                             job status
interface q_fifo_feed_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] num_words;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic             out_ready;
   logic             out_valid;
   logic             fifo_clr;
   logic             fifo_write_en;
   logic [31:0]      fifo_write_data;
   logic             fifo_read_en;
   logic             busy;
   logic             done;

   modport slave (
      input  start, num_words, in_valid, in_data, out_ready,
      output in_ready, out_valid, fifo_clr, fifo_write_en, fifo_write_data,
             fifo_read_en, busy, done
   );

   modport master (
      output start, num_words, in_valid, in_data, out_ready,
      input  in_ready, out_valid, fifo_clr, fifo_write_en, fifo_write_data,
             fifo_read_en, busy, done
   );
endinterface

// File: rtl/q_fifo_feed_ctrl.sv
// Sequencer for the Q-projection input packing FIFO.
// Each FIFO write stores one 32-bit word as four bytes plus (GROUP-4) zero
// pad slots; each FIFO read pops one byte. The controller runs one job of
// num_words words: it admits an upstream word only when GROUP slots are free,
// pops bytes whenever the consumer asks and data is present, and pulses done
// once all GROUP*num_words bytes have been presented.
// The FIFO's own full/empty flags are not used: occupancy is mirrored in occ.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    q_fifo_feed_ctrl_if.slave (job control, word stream, byte
//          stream, FIFO controls, busy/done)
module q_fifo_feed_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 14,
   parameter int GROUP      = 7,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   q_fifo_feed_ctrl_if.slave bus
);

   localparam int OCC_W  = $clog2(DEPTH) + 1;
   localparam int BYTE_W = CNT_W + 3;

   localparam logic [OCC_W-1:0] OCC_WR    = OCC_W'(GROUP);
   localparam logic [OCC_W-1:0] OCC_WR_RD = OCC_W'(GROUP - 1);
   localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
   // A new word fits only while occ leaves room for a whole group.
   localparam logic [OCC_W-1:0] OCC_ADMIT = OCC_W'(DEPTH - GROUP);

   // A group must hold every byte of a word, and fit in the FIFO at all.
   if ((GROUP < (32 / DATA_WIDTH)) || (GROUP > DEPTH)) begin : g_bad_cfg
      $error("q_fifo_feed_ctrl: GROUP must cover one word and fit in DEPTH");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   num_words_q;
   logic [CNT_W-1:0]   words_wr;
   logic [BYTE_W-1:0]  total_bytes_q;
   logic [BYTE_W-1:0]  bytes_rd;
   logic [OCC_W-1:0]   occ;
   logic               rst_clr_q;
   logic               rd_vld_q;

   logic               in_ready;
   logic               wr;
   logic               rd;
   logic               busy_c;
   logic               done_c;
   logic               clr_c;

   // ------------------------------------------------------------------
   // Handshake decode (combinational from registered state + inputs)
   // ------------------------------------------------------------------
   assign in_ready = (state == S_RUN) && (occ <= OCC_ADMIT) &&
                     (words_wr < num_words_q);
   assign wr       = bus.in_valid && in_ready;
   // occ is the registered value, so a same-cycle write can never make an
   // empty FIFO look readable.
   assign rd       = bus.out_ready && (occ != '0) &&
                     ((state == S_RUN) || (state == S_DRAIN)) &&
                     (bytes_rd < total_bytes_q);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b1;
      done_c    = 1'b0;
      clr_c     = 1'b0;
      case (state)
         S_IDLE: begin
            busy_c = 1'b0;
            if (bus.start) state_nxt = S_CLR;
         end
         S_CLR: begin
            clr_c     = 1'b1;
            state_nxt = (num_words_q == '0) ? S_FIN : S_RUN;
         end
         S_RUN: begin
            // Leave as the last word is taken; reads continue in DRAIN.
            if (wr && ((words_wr + CNT_W'(1)) == num_words_q))
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // All bytes issued and nothing more in flight: the final
            // out_valid is this cycle, done follows next cycle.
            if ((bytes_rd == total_bytes_q) && !rd) state_nxt = S_FIN;
         end
         S_FIN: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Job registers, counters, occupancy mirror
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_words_q   <= '0;
         total_bytes_q <= '0;
         words_wr      <= '0;
         bytes_rd      <= '0;
         occ           <= '0;
         rst_clr_q     <= 1'b1;
         rd_vld_q      <= 1'b0;
      end else begin
         // Keeps fifo_clr high for the first edge after reset release so
         // the FIFO sees its synchronous reset.
         rst_clr_q <= 1'b0;
         // FIFO read_data is registered, so valid trails the read by one.
         rd_vld_q  <= rd;

         if ((state == S_IDLE) && bus.start) begin
            num_words_q   <= bus.num_words;
            total_bytes_q <= BYTE_W'(bus.num_words) * BYTE_W'(GROUP);
         end

         if (state == S_CLR) begin
            occ      <= '0;
            words_wr <= '0;
            bytes_rd <= '0;
         end else begin
            case ({wr, rd})
               2'b10:   occ <= occ + OCC_WR;
               2'b01:   occ <= occ - OCC_ONE;
               2'b11:   occ <= occ + OCC_WR_RD;
               default: occ <= occ;
            endcase
            if (wr) words_wr <= words_wr + CNT_W'(1);
            if (rd) bytes_rd <= bytes_rd + BYTE_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.in_ready        = in_ready;
   assign bus.fifo_write_en   = wr;
   assign bus.fifo_write_data = bus.in_data;
   assign bus.fifo_read_en    = rd;
   assign bus.out_valid       = rd_vld_q;
   assign bus.fifo_clr        = rst_clr_q | clr_c;
   assign bus.busy            = busy_c;
   assign bus.done            = done_c;

endmodule

// File: tb/tb_q_fifo_feed_ctrl.sv
// Self-checking bench for q_fifo_feed_ctrl.
// A behavioural FIFO (byte queue) sits on the DUT's FIFO controls. A job
// model tracks each job by cycles-since-start, words accepted and bytes read,
// and predicts every handshake output from queue occupancy each cycle; an
// expected-byte queue built from accepted upstream words checks byte order.
// Randomized jobs come from a table; multi-cycle corners are directed.
module tb_q_fifo_feed_ctrl;
   localparam int DW    = 8;
   localparam int DEPTH = 14;
   localparam int GROUP = 7;
   localparam int CNT_W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   q_fifo_feed_ctrl_if #(.CNT_W(CNT_W)) bus ();

   q_fifo_feed_ctrl #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .GROUP      (GROUP),
      .CNT_W      (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------
   // Reference model (evaluated on the falling edge)
   // ---------------------------------------------------------------
   logic [7:0] fq[$];       // FIFO contents
   logic [7:0] wq[$];       // expected byte stream from accepted words
   logic [7:0] seen_q[$];   // bytes presented in the current job
   int         acc_pre[$];  // occupancy before each acceptance
   int         acc_post[$]; // occupancy after each acceptance
   logic       pend_rd = 1'b0;
   logic [7:0] pend_data = 8'h00;
   bit         live, prev_cmp, first_rel, run, e_rdy, e_rd, e_done;
   int         since, acc, rd_cnt, n_job, sz0, acc0, rd0;
   int         tot_done = 0, tot_wr = 0, tot_rd = 0, job_bytes = 0, job_done = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         fq.delete();
         wq.delete();
         pend_rd   = 1'b0;
         live      = 1'b0;
         prev_cmp  = 1'b0;
         first_rel = 1'b1;
         since     = 0;
         acc       = 0;
         rd_cnt    = 0;
         n_job     = 0;
      end else begin
         // Byte from the read issued last cycle.
         chk1("out_valid", bus.out_valid, pend_rd);
         if (bus.out_valid) job_bytes++;
         if (pend_rd) begin
            seen_q.push_back(pend_data);
            if (wq.size() != 0) chk("byte_order", int'(pend_data), int'(wq.pop_front()));
            else chk("byte_surplus", 1, 0);
         end

         sz0    = fq.size();
         acc0   = acc;
         rd0    = rd_cnt;
         run    = live && (since >= 2);
         e_rdy  = run && (acc < n_job) && (sz0 <= DEPTH - GROUP);
         e_rd   = run && bus.out_ready && (sz0 != 0) && (rd_cnt < GROUP * n_job);
         e_done = prev_cmp;

         chk1("in_ready", bus.in_ready, e_rdy);
         chk1("fifo_write_en", bus.fifo_write_en, bus.in_valid && e_rdy);
         if (bus.fifo_write_en) chk("fifo_write_data", bus.fifo_write_data, bus.in_data);
         chk1("fifo_read_en", bus.fifo_read_en, e_rd);
         chk1("busy", bus.busy, live);
         chk1("done", bus.done, e_done);
         chk1("fifo_clr", bus.fifo_clr, first_rel || (live && since == 1));

         // Advance the FIFO by this cycle's actions.
         pend_rd = 1'b0;
         if (bus.fifo_clr) begin
            fq.delete();
         end else begin
            if (bus.fifo_read_en) begin
               tot_rd++;
               rd_cnt++;
               if (fq.size() == 0) chk("read_on_empty", 1, 0);
               else begin
                  pend_data = fq.pop_front();
                  pend_rd   = 1'b1;
               end
            end
            if (bus.fifo_write_en) begin
               tot_wr++;
               for (int i = 3; i >= 0; i--) fq.push_back(bus.fifo_write_data[8*i +: 8]);
               repeat (GROUP - 4) fq.push_back(8'h00);
            end
            chk1("occupancy_bound", fq.size() <= DEPTH, 1'b1);
         end

         if (bus.in_valid && bus.in_ready) begin
            acc++;
            acc_pre.push_back(sz0);
            acc_post.push_back(fq.size());
            for (int i = 3; i >= 0; i--) wq.push_back(bus.in_data[8*i +: 8]);
            repeat (GROUP - 4) wq.push_back(8'h00);
         end
         if (bus.done) begin
            tot_done++;
            job_done++;
         end

         // All words in and all bytes presented: done next cycle.
         prev_cmp = live && (since >= 1) && (acc0 == n_job) && (rd0 == GROUP * n_job);

         if (!live && bus.start) begin
            live      = 1'b1;
            since     = 1;
            n_job     = int'(bus.num_words);
            acc       = 0;
            rd_cnt    = 0;
            prev_cmp  = 1'b0;
            job_bytes = 0;
            job_done  = 0;
            seen_q.delete();
            wq.delete();
            acc_pre.delete();
            acc_post.delete();
         end else if (live) begin
            since++;
         end
         if (e_done) begin
            live     = 1'b0;
            prev_cmp = 1'b0;
         end
         first_rel = 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n);
      bus.num_words = CNT_W'(n);
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.num_words = '1;   // the latched copy must be the one in use
   endtask

   // vp/rp < 0 leave in_valid/out_ready as they are.
   task automatic wait_done(input string name, input int vp, input int rp, input int budget);
      int  d0;
      bit  ok;
      d0 = tot_done;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (vp >= 0) begin
            bus.in_valid = ($urandom_range(99) < vp);
            bus.in_data  = $urandom;
         end
         if (rp >= 0) bus.out_ready = ($urandom_range(99) < rp);
         tick();
         if ((tot_done > d0) && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk1({name, "_completes"}, ok, 1'b1);
   endtask

   typedef struct {
      int n;
      int vp;
      int rp;
      int exp_bytes;
      int exp_done;
   } job_t;

   job_t       jobs [7];
   logic [7:0] sw_exp [7];
   int         d0, w0, r0;

   initial begin
      jobs = '{
         '{1, 100, 100,  7, 1},
         '{3,  60,  40, 21, 1},
         '{5,  30,  90, 35, 1},
         '{8,  90,  20, 56, 1},
         '{2,  50,  50, 14, 1},
         '{0,  50,  50,  0, 1},
         '{6, 100, 100, 42, 1}
      };
      sw_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00};

      // ---- reset: inputs active, outputs must stay quiet ----
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.num_words = '0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hDEADBEEF;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      chk1("rst_fifo_clr",  bus.fifo_clr, 1'b1);
      chk1("rst_in_ready",  bus.in_ready, 1'b0);
      chk1("rst_write_en",  bus.fifo_write_en, 1'b0);
      chk1("rst_read_en",   bus.fifo_read_en, 1'b0);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_busy",      bus.busy, 1'b0);
      chk1("rst_done",      bus.done, 1'b0);
      tick();
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      chk1("rel_fifo_clr_first", bus.fifo_clr, 1'b1);
      tick();
      #2;
      chk1("rel_fifo_clr_second", bus.fifo_clr, 1'b0);
      chk1("rel_busy", bus.busy, 1'b0);

      // ---- single word, byte order ----
      tick();
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA1B2C3D4;
      bus.out_ready = 1'b1;
      start_job(1);
      wait_done("single", -1, -1, 200);
      chk("single_nbytes", seen_q.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < seen_q.size()) chk("single_byte", int'(seen_q[i]), int'(sw_exp[i]));
      chk("single_done", job_done, 1);
      chk1("single_idle_after", bus.busy, 1'b0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      // ---- backpressure: two words fill the FIFO, third at occ==7 ----
      start_job(4);
      bus.in_valid = 1'b1;
      repeat (12) begin
         bus.in_data = $urandom;
         tick();
      end
      #2;
      chk("bp_accepted", acc, 2);
      chk("bp_occ", fq.size(), 14);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
      tick();
      bus.out_ready = 1'b1;
      wait_done("bp", 100, -1, 400);
      chk("bp_words", acc_pre.size(), 4);
      if (acc_pre.size() >= 3) begin
         chk("bp_third_occ_before", acc_pre[2], 7);
         chk("bp_third_occ_after", acc_post[2], 13);
      end
      chk("bp_bytes", job_bytes, 28);
      chk("bp_done", job_done, 1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      // ---- zero length ----
      w0 = tot_wr;
      r0 = tot_rd;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      start_job(0);
      #2;
      chk1("zero_clr_cycle", bus.fifo_clr, 1'b1);
      chk1("zero_no_done_yet", bus.done, 1'b0);
      tick();
      #2;
      chk1("zero_done_at_2", bus.done, 1'b1);
      tick();
      #2;
      chk1("zero_done_single", bus.done, 1'b0);
      chk1("zero_idle", bus.busy, 1'b0);
      chk("zero_no_writes", tot_wr, w0);
      chk("zero_no_reads", tot_rd, r0);
      tick();

      // ---- start pulsed during RUN is ignored ----
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      start_job(3);
      repeat (3) tick();
      bus.num_words = CNT_W'(9);
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      wait_done("ign_start", 60, 70, 600);
      chk("ign_start_bytes", job_bytes, 21);
      chk("ign_start_done", job_done, 1);

      // ---- randomized table jobs ----
      foreach (jobs[j]) begin
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b0;
         tick();
         start_job(jobs[j].n);
         wait_done("table", jobs[j].vp, jobs[j].rp, 3000);
         chk("table_bytes", job_bytes, jobs[j].exp_bytes);
         chk("table_done", job_done, jobs[j].exp_done);
      end

      // ---- asynchronous reset during DRAIN ----
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      start_job(2);
      repeat (6) begin
         bus.in_data = $urandom;
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      tick();
      #2;
      chk1("mid_busy_before", bus.busy, 1'b1);
      chk1("mid_out_valid_before", bus.out_valid, 1'b1);
      d0    = tot_done;
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_fifo_clr",  bus.fifo_clr, 1'b1);
      chk1("mid_rst_busy",      bus.busy, 1'b0);
      chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
      chk1("mid_rst_read_en",   bus.fifo_read_en, 1'b0);
      chk1("mid_rst_in_ready",  bus.in_ready, 1'b0);
      chk1("mid_rst_done",      bus.done, 1'b0);
      repeat (3) begin
         tick();
         #2;
         chk1("mid_rst_hold_done", bus.done, 1'b0);
      end
      tick();
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("mid_rst_no_done", tot_done, d0);
      start_job(1);
      wait_done("post_rst", 70, 70, 400);
      chk("post_rst_bytes", job_bytes, 7);
      chk("post_rst_done", job_done, 1);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/q_fifo_feed_ctrl.md
# q_fifo_feed_ctrl

Sequencer for the Q-projection input packing FIFO: the FIFO that stores each 32-bit write as four bytes plus three zero pad slots (7 slots per write) and pops one byte per read. The block accepts a job of `num_words` 32-bit words over a valid/ready stream. It issues FIFO writes only when 7 slots are free and pops bytes toward the downstream consumer on demand. It signals completion once all 7·`num_words` bytes have been delivered. It mirrors the FIFO occupancy internally, so the FIFO's `full`/`empty` flags are not needed for flow control.

## Interface
- `DATA_WIDTH`, default 8: FIFO byte width.
- `DEPTH`, default 14: FIFO slot count; must equal the FIFO's `DEPTH`.
- `GROUP`, default 7: slots consumed per FIFO write (4 data + 3 pad).
- `CNT_W`, default 16: width of `num_words`.
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: job start pulse; sampled only in IDLE.
- `num_words` input, `CNT_W` bits: 32-bit words in the job; latched on an accepted `start`.
- `in_valid` input, 1 bit: upstream word valid.
- `in_data` input, 32 bits: upstream word.
- `in_ready` output, 1 bit: a word is accepted this cycle when `in_valid && in_ready`.
- `out_ready` input, 1 bit: downstream requests one byte.
- `out_valid` output, 1 bit: the FIFO's `read_data` is valid this cycle.
- `fifo_clr` output, 1 bit: drives the FIFO's synchronous active-high `rst`.
- `fifo_write_en` output, 1 bit: drives the FIFO's `write_en`.
- `fifo_write_data` output, 32 bits: drives the FIFO's `write_data`; equals `in_data`.
- `fifo_read_en` output, 1 bit: drives the FIFO's `read_en`.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse at job completion.

## Operation
- **States:** IDLE, CLR, RUN, DRAIN, FIN.
- **IDLE:**
  - `start` latches `num_words` and goes to CLR.
  - `start` is ignored in every other state.
- **CLR:**
  - `fifo_clr`=1 for exactly one cycle.
  - Clears `occ`, `words_wr` and `bytes_rd`.
  - Goes to RUN, or to FIN if the latched `num_words`==0.
- **Occupancy counter `occ`:** width `$clog2(DEPTH)`+1, updated every cycle as follows.
  - Write only: +`GROUP`.
  - Read only: −1.
  - Write and read in the same cycle: +(`GROUP`−1).
  - Neither: unchanged.
- **Accept condition:** `in_ready` = (state==RUN) && (`DEPTH`−`occ` ≥ `GROUP`) && (`words_wr` < `num_words`).
- **Write:** `fifo_write_en` = `in_valid && in_ready`; `words_wr` increments on each accepted word.
- **Read condition:** `fifo_read_en` = `out_ready` && (`occ` ≠ 0) && (state ∈ {RUN, DRAIN}) && (`bytes_rd` < `GROUP`·`num_words`).
- **Byte counter:** `bytes_rd`, width `CNT_W`+3, increments on each issued read.
- **RUN → DRAIN** on the cycle `words_wr` reaches `num_words`.
- **DRAIN → FIN** when `bytes_rd` == `GROUP`·`num_words` and no read is in flight (`out_valid` about to drop).
- **FIN:** `done`=1 for one cycle, then IDLE.
- **Byte order per word:** `in_data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`, then 0, 0, 0.
- **Mirror invariant:** `occ` always equals the FIFO's `used_space`, so `occ` never exceeds `DEPTH` and a read is never issued to an empty FIFO.
- **Simultaneous write and read with `occ`==0:** not possible, because the read condition requires `occ` ≠ 0 on the registered value.

## Timing
- **Reset values:**
  - `fifo_clr`=1; it drops after the first clock edge following `rst_n` deassertion, so the FIFO receives a synchronous reset.
  - All other outputs 0; state is IDLE; all counters are 0.
- **Asynchronous reset mid-job:** everything returns to the reset values immediately, and no `done` is issued.
- **Combinational (same-cycle) outputs:** `in_ready`, `fifo_write_en` and `fifo_read_en` are combinational from the current state and counters plus `in_valid`/`out_ready`.
- **`out_valid`:** registered; it equals `fifo_read_en` delayed by one cycle, matching the FIFO's registered `read_data`.
- **Start latency:** 1 cycle from `start` to CLR, and 2 cycles until `in_ready` can rise.
- **Write admission:** with `DEPTH`=14, at most 2 words are outstanding. A third word is admitted once `occ` ≤ 7.
- **Throughput:** with `out_ready` held high, 1 byte per cycle after the first write.
- **`done` timing:** `done` rises in the cycle after the final `out_valid`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release -> `fifo_clr` is 1 for the first cycle only; all other outputs are 0; `busy`=0.
- **Single word:** `num_words`=1, `in_data`=0xA1B2C3D4, `out_ready`=1 -> 7 `out_valid` bytes A1, B2, C3, D4, 00, 00, 00, then `done` once, then `busy`=0.
- **Backpressure:** `num_words`=4, `out_ready`=0, `in_valid`=1 -> exactly 2 words accepted, `occ`=14, `in_ready`=0. Then raise `out_ready` -> third word accepted on the cycle `occ` reaches 7, and `done` after 28 bytes.
- **Write/read collision:** `occ`=7, a write and a read in the same cycle -> `occ`=13 next cycle; the byte sequence stays intact.
- **Zero length and ignored start:** `num_words`=0 -> IDLE→CLR→FIN with `done` 2 cycles after `start` and no FIFO activity. A `start` pulsed during RUN is ignored.
- **Mid-job reset:** pull `rst_n` low during DRAIN -> outputs return to the reset values immediately with no `done`. A new 1-word job then completes normally.
